// File: rtl/nn_pkg.sv
// nn_pkg: shared types and helpers for the dense-layer pipeline control.
package nn_pkg;
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_RELU,
    ACT_SIGMOID,
    ACT_TANH
  } activation_type;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_OUTPUT,
    ST_ERROR
  } seq_state_e;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: host handshake, layer control strobes and status of the sequencer.
interface layer_sequencer_if import nn_pkg::*; #(
  parameter int NUM_LAYERS  = 3,
  parameter int COUNT_WIDTH = 16
) ();
  localparam int IW = idx_width(NUM_LAYERS);
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LAYERS-1:0]  layer_start;
  logic [NUM_LAYERS-1:0]  layer_done;
  logic [NUM_LAYERS-1:0]  capture_en;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   error;
  logic [IW-1:0]          current_layer;
  logic [COUNT_WIDTH-1:0] latency;
  modport master (
    input  in_valid, layer_done, out_ready,
    output in_ready, layer_start, capture_en, out_valid, busy, error, current_layer, latency
  );
  modport slave (
    output in_valid, layer_done, out_ready,
    input  in_ready, layer_start, capture_en, out_valid, busy, error, current_layer, latency
  );
endinterface

// File: rtl/layer_watchdog.sv
// layer_watchdog: arms on a low layer_done so a stale level cannot complete a layer,
// and flags a timeout when the current layer runs too long.
module layer_watchdog import nn_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  input  logic wait_i,
  input  logic done_i,
  output logic complete_o,
  output logic timeout_o
);
  localparam int CW = idx_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // START drops any previous arming but still samples done, so a layer that
  // falls during START and rises in the first WAIT cycle completes in 3 cycles.
  always_comb begin
    armed_d = start_i ? !done_i : (armed_q | (wait_i & !done_i));
    cnt_d   = start_i ? '0 : wait_i ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end
  assign complete_o = wait_i & armed_q & done_i;
  assign timeout_o  = wait_i & (cnt_q == LIMIT);
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs NUM_LAYERS dense layers in turn per input vector, with
// per-layer timeout and a saturating bring-up latency counter.
module layer_sequencer import nn_pkg::*; #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int COUNT_WIDTH    = 16
) (
  input logic clock,
  input logic reset,
  layer_sequencer_if.master bus
);
  localparam int IW = idx_width(NUM_LAYERS);
  localparam logic [IW-1:0] LAST = IW'(NUM_LAYERS - 1);
  seq_state_e             state_q, state_d;
  logic [IW-1:0]          layer_q, layer_d;
  logic [COUNT_WIDTH-1:0] run_q, run_d, lat_q, lat_d;
  logic [NUM_LAYERS-1:0]  onehot;
  logic                   done_sel, complete, timeout, run_step;
  assign onehot   = NUM_LAYERS'(1) << layer_q;
  assign done_sel = bus.layer_done[layer_q];
  assign run_step = state_q inside {ST_START, ST_WAIT, ST_CAPTURE};
  layer_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .start_i    (state_q == ST_START),
    .wait_i     (state_q == ST_WAIT),
    .done_i     (done_sel),
    .complete_o (complete),
    .timeout_o  (timeout)
  );
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    run_d   = run_step ? ((&run_q) ? run_q : run_q + COUNT_WIDTH'(1)) : run_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_START;
          layer_d = '0;
          run_d   = '0;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: state_d = complete ? ST_CAPTURE : timeout ? ST_ERROR : ST_WAIT;
      ST_CAPTURE: begin
        if (layer_q == LAST) begin
          state_d = ST_OUTPUT;
          lat_d   = run_d;
        end else begin
          state_d = ST_START;
          layer_d = layer_q + IW'(1);
        end
      end
      ST_OUTPUT: state_d = bus.out_ready ? ST_IDLE : ST_OUTPUT;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      run_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      run_q   <= run_d;
      lat_q   <= lat_d;
    end
  end
  // Strobes are masked while reset is high so an abort never leaks a pulse.
  assign bus.layer_start   = (state_q == ST_START && !reset) ? onehot : '0;
  assign bus.capture_en    = (state_q == ST_CAPTURE && !reset) ? onehot : '0;
  assign bus.out_valid     = (state_q == ST_OUTPUT) && !reset;
  assign bus.in_ready      = (state_q == ST_IDLE);
  assign bus.busy          = !(state_q inside {ST_IDLE, ST_ERROR});
  assign bus.error         = (state_q == ST_ERROR);
  assign bus.current_layer = layer_q;
  assign bus.latency       = lat_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed stimulus with a queue scoreboard for start/capture/result events.
module tb_layer_sequencer;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  int start_q[$];
  int cap_q[$];
  int lat_q[$];
  bit fall_en = 1'b1;
  int high_dly = 4;
  int cd[3] = '{default: 0};
  layer_sequencer_if #(.NUM_LAYERS(3), .COUNT_WIDTH(16)) bus ();
  layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  task automatic push_vec(input int lat);
    for (int i = 0; i < 3; i++) begin
      start_q.push_back(i);
      cap_q.push_back(i);
    end
    lat_q.push_back(lat);
  endtask
  task automatic send();
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < budget);
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_out: no out_valid within %0d cycles", budget);
    end
  endtask
  task automatic wait_start(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.layer_start[idx] && n < budget);
    if (!bus.layer_start[idx]) begin
      tests++;
      fails++;
      $display("FAIL wait_start: no start on layer %0d within %0d cycles", idx, budget);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_layer_start"}, bus.layer_start, 0);
    chk({tag, "_capture_en"}, bus.capture_en, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_current_layer"}, bus.current_layer, 0);
    chk({tag, "_latency"}, bus.latency, 0);
  endtask
  // Layer model: done falls one cycle after start and rises high_dly cycles later.
  initial begin
    bus.layer_done = '1;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (!rst && bus.layer_start[g] && fall_en) cd[g] = high_dly + 1;
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++)
        if (cd[g] > 0) begin
          cd[g]--;
          bus.layer_done[g] = (cd[g] == 0);
        end
    end
  end
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.layer_start != '0) begin
          if (start_q.size() == 0) chk("start_unexpected", bus.layer_start, 0);
          else begin
            e = start_q.pop_front();
            chk("start_onehot", bus.layer_start, 1 << e);
            chk("start_index", bus.current_layer, e);
          end
        end
        if (bus.capture_en != '0) begin
          if (cap_q.size() == 0) chk("capture_unexpected", bus.capture_en, 0);
          else begin
            e = cap_q.pop_front();
            chk("capture_onehot", bus.capture_en, 1 << e);
            chk("capture_index", bus.current_layer, e);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (lat_q.size() == 0) chk("out_unexpected", bus.out_valid, 0);
          else chk("latency", bus.latency, lat_q.pop_front());
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    // Nominal three-layer run, 7 cycles per layer.
    @(posedge clk);
    #1;
    push_vec(21);
    send();
    wait_out(100);
    chk("run_busy", bus.busy, 1);
    chk("run_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("ov_one_cycle", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("latency_hold", bus.latency, 21);
    // Backpressure: result held for 10 cycles, accepted on the 11th.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push_vec(21);
    send();
    wait_out(100);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_no_start", bus.layer_start, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_out_valid", bus.out_valid, 0);
    chk("bp_done_in_ready", bus.in_ready, 1);
    // Back-to-back vectors with in_valid held; stale done must be rejected.
    @(posedge clk);
    #1;
    push_vec(21);
    push_vec(21);
    bus.in_valid = 1'b1;
    wait_out(100);
    chk("b2b_in_ready_out", bus.in_ready, 0);
    @(negedge clk);
    chk("b2b_accept_ready", bus.in_ready, 1);
    chk("b2b_ov_low", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_start_next", bus.layer_start, 1);
    wait_out(100);
    // Completion on the final timeout cycle wins over the timeout.
    @(posedge clk);
    #1;
    high_dly = 7;
    push_vec(30);
    send();
    wait_out(200);
    chk("race_error", bus.error, 0);
    high_dly = 4;
    // Reset during WAIT of layer 1.
    @(posedge clk);
    #1;
    push_vec(21);
    send();
    wait_start(1, 100);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    chk("mid_layer", bus.current_layer, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_start", bus.layer_start, 0);
    chk("rst_cycle_capture", bus.capture_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_q.delete();
    cap_q.delete();
    lat_q.delete();
    @(negedge clk);
    chk_reset_vals("abort");
    @(posedge clk);
    #1;
    push_vec(21);
    send();
    wait_out(100);
    // Stale done that never falls: timeout after 8 WAIT cycles.
    @(posedge clk);
    #1;
    fall_en = 1'b0;
    start_q.push_back(0);
    send();
    wait_start(0, 50);
    repeat (8) @(negedge clk);
    chk("stale_no_error_yet", bus.error, 0);
    chk("stale_busy", bus.busy, 1);
    @(negedge clk);
    chk("stale_error", bus.error, 1);
    chk("stale_in_ready", bus.in_ready, 0);
    chk("stale_busy_low", bus.busy, 0);
    chk("stale_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("err_sticky", bus.error, 1);
      chk("err_in_ready", bus.in_ready, 0);
      chk("err_no_start", bus.layer_start, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fall_en = 1'b1;
    @(negedge clk);
    chk("err_cleared", bus.error, 0);
    chk("err_cleared_ready", bus.in_ready, 1);
    chk("drain_start", start_q.size(), 0);
    chk("drain_capture", cap_q.size(), 0);
    chk("drain_result", lat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
